// File: rtl/mux_nto1_scan_pkg.sv
// Shared constants and helpers for the N-to-1 scanning multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Index width that never collapses to zero bits, even for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_scan_if.sv
// Channel inputs, control and registered selection outputs of the scanning multiplexer.
interface mux_nto1_scan_if
    import mux_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = clog2_min1(NUM_CH),
    parameter int DWELL_W = 4
);
    logic [NUM_CH*DATA_W-1:0] din;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        ch_en;
    logic [DWELL_W-1:0]       dwell;
    logic [DATA_W-1:0]        y;
    logic [SEL_W-1:0]         y_ch;
    logic                     y_valid;
    logic                     scan_wrap;

    modport master (
        output din, mode, sel, ch_en, dwell,
        input  y, y_ch, y_valid, scan_wrap
    );

    modport slave (
        input  din, mode, sel, ch_en, dwell,
        output y, y_ch, y_valid, scan_wrap
    );

endinterface

// File: rtl/mux_nto1_scan_next.sv
// Cyclic search for the next enabled channel strictly after ptr.
module mux_scan_next #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [SEL_W-1:0]  ptr,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [SEL_W-1:0]  next_idx,
    output logic              any_en,
    output logic              wrap
);

    int cand;

    // Walk offsets from farthest to nearest so the closest enabled channel wins.
    always_comb begin
        next_idx = '0;
        any_en   = 1'b0;
        cand     = 0;
        for (int off = NUM_CH; off >= 1; off--) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (ch_en[cand]) begin
                next_idx = SEL_W'(cand);
                any_en   = 1'b1;
            end
        end
        wrap = any_en && (next_idx <= ptr);
    end

endmodule

// File: rtl/mux_nto1_scan.sv
// N-to-1 registered multiplexer with manual select or a dwell-timed scan over enabled channels.
//   mode_q      | meaning
//   MODE_MANUAL | external sel drives the output register
//   MODE_SCAN   | internal ptr/dwell_cnt sequencer drives the output register
module mux_nto1_scan
    import mux_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = clog2_min1(NUM_CH),
    parameter int DWELL_W = 4
) (
    input logic           clk,
    input logic           rst_n,
    mux_nto1_scan_if.slave bus
);

    logic               mode_q,      mode_q_d;
    logic [SEL_W-1:0]   ptr,         ptr_d;
    logic [DWELL_W-1:0] dwell_cnt,   dwell_cnt_d;
    logic               ptr_wrapped, ptr_wrapped_d;
    logic [DATA_W-1:0]  y_q,         y_d;
    logic [SEL_W-1:0]   y_ch_q,      y_ch_d;
    logic               y_valid_q,   y_valid_d;
    logic               scan_wrap_q, scan_wrap_d;

    logic [SEL_W-1:0]   next_idx, low_idx, word_idx;
    logic               any_en, next_wrap, low_any, low_wrap_unused;
    logic [DATA_W-1:0]  word;
    logic               ptr_en, mode_switch, sel_ok;

    mux_scan_next #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_next (
        .ptr      (ptr),
        .ch_en    (bus.ch_en),
        .next_idx (next_idx),
        .any_en   (any_en),
        .wrap     (next_wrap)
    );

    // Searching after the last channel yields the lowest enabled index.
    mux_scan_next #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_low (
        .ptr      (SEL_W'(NUM_CH - 1)),
        .ch_en    (bus.ch_en),
        .next_idx (low_idx),
        .any_en   (low_any),
        .wrap     (low_wrap_unused)
    );

    always_comb begin
        mode_switch = (bus.mode != mode_q);
        sel_ok      = (int'(bus.sel) < NUM_CH);
        if (bus.mode == MODE_MANUAL) word_idx = bus.sel;
        else if (mode_switch)        word_idx = low_idx;
        else                         word_idx = ptr;

        word   = '0;
        ptr_en = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(word_idx) == k) word = bus.din[k*DATA_W +: DATA_W];
            if (int'(ptr) == k)      ptr_en = bus.ch_en[k];
        end
    end

    always_comb begin
        mode_q_d      = bus.mode;
        ptr_d         = ptr;
        dwell_cnt_d   = dwell_cnt;
        ptr_wrapped_d = 1'b0;
        y_d           = y_q;
        y_ch_d        = y_ch_q;
        y_valid_d     = y_valid_q;
        scan_wrap_d   = 1'b0;

        if (bus.mode == MODE_MANUAL) begin
            if (mode_switch) dwell_cnt_d = '0;
            if (sel_ok) begin
                y_d       = word;
                y_ch_d    = bus.sel;
                y_valid_d = 1'b1;
            end else begin
                y_valid_d = 1'b0;
            end
        end else if (mode_switch) begin
            ptr_d       = low_idx;
            dwell_cnt_d = '0;
            y_d         = word;
            y_ch_d      = low_idx;
            y_valid_d   = low_any;
        end else begin
            y_d       = word;
            y_ch_d    = ptr;
            y_valid_d = ptr_en;
            if (any_en) begin
                // The wrap pulse lines up with the first output taken from the wrapped-to channel.
                scan_wrap_d = ptr_wrapped;
                if (!ptr_en || dwell_cnt >= bus.dwell) begin
                    ptr_d         = next_idx;
                    dwell_cnt_d   = '0;
                    ptr_wrapped_d = next_wrap;
                end else begin
                    dwell_cnt_d = dwell_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_MANUAL;
            ptr         <= '0;
            dwell_cnt   <= '0;
            ptr_wrapped <= 1'b0;
            y_q         <= '0;
            y_ch_q      <= '0;
            y_valid_q   <= 1'b0;
            scan_wrap_q <= 1'b0;
        end else begin
            mode_q      <= mode_q_d;
            ptr         <= ptr_d;
            dwell_cnt   <= dwell_cnt_d;
            ptr_wrapped <= ptr_wrapped_d;
            y_q         <= y_d;
            y_ch_q      <= y_ch_d;
            y_valid_q   <= y_valid_d;
            scan_wrap_q <= scan_wrap_d;
        end
    end

    assign bus.y         = y_q;
    assign bus.y_ch      = y_ch_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.scan_wrap = scan_wrap_q;

endmodule
